// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA constants, settings record and pixel compose helper
package vga_pkg;

  localparam int CHAR_W = 8;
  localparam int CHAR_H = 16;
  localparam int CNT_W  = 11;
  localparam int RGB_W  = 12;

  localparam logic [1:0] MODE_OPAQUE = 2'b00;
  localparam logic [1:0] MODE_TRANSP = 2'b01;
  localparam logic [1:0] MODE_BYPASS = 2'b10;
  localparam logic [1:0] MODE_INVERT = 2'b11;

  // Settings that are captured once per frame so a frame never mixes old and new values.
  typedef struct packed {
    logic [RGB_W-1:0] fg;
    logic [RGB_W-1:0] bg;
    logic [1:0]       mode;
    logic             cursor_en;
    logic [5:0]       cursor_col;
    logic [3:0]       cursor_row;
  } settings_t;

  localparam settings_t SETTINGS_DEFAULT = '{
    fg:         12'hFFF,
    bg:         12'h000,
    mode:       MODE_OPAQUE,
    cursor_en:  1'b0,
    cursor_col: 6'd0,
    cursor_row: 4'd0
  };

  // Final colour of one pixel. A cursor cell swaps fg/bg first; a transparent
  // cursor cell paints its background so the cursor stays visible.
  function automatic logic [RGB_W-1:0] compose_pixel(
    input logic             pix,
    input logic             in_box,
    input logic             cursor,
    input logic [1:0]       mode,
    input logic [RGB_W-1:0] fg,
    input logic [RGB_W-1:0] bg,
    input logic [RGB_W-1:0] under
  );
    logic [RGB_W-1:0] f;
    logic [RGB_W-1:0] b;
    f = cursor ? bg : fg;
    b = cursor ? fg : bg;
    if (!in_box || mode == MODE_BYPASS) begin
      return under;
    end
    case (mode)
      MODE_OPAQUE: return pix ? f : b;
      MODE_TRANSP: return pix ? f : (cursor ? b : under);
      default:     return pix ? b : f;
    endcase
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - fixed-depth register chain with async active-low reset
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] taps [DEPTH];

  // Shift the word one tap per clock; reset flushes every tap to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        taps[i] <= '0;
      end
    end else begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/draw_text_box.sv
// rtl/draw_text_box.sv - text overlay stage: glyph grid addressing, cursor, compose, timing delay
module draw_text_box
  import vga_pkg::*;
#(
  parameter int BOX_X     = 200,
  parameter int BOX_Y     = 400,
  parameter int COLS      = 30,
  parameter int ROWS      = 1,
  parameter int SCALE_LOG = 0,
  parameter int ROM_LAT   = 2,
  parameter int BLINK_LOG = 5
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [7:0]  char_pixels,
  input  logic [11:0] fg_rgb,
  input  logic [11:0] bg_rgb,
  input  logic [1:0]  mode,
  input  logic        cursor_en,
  input  logic [5:0]  cursor_col,
  input  logic [3:0]  cursor_row,
  output logic [9:0]  char_xy,
  output logic [3:0]  char_line,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam int LAT   = ROM_LAT + 2;
  localparam int BOX_W = (COLS * CHAR_W) << SCALE_LOG;
  localparam int BOX_H = (ROWS * CHAR_H) << SCALE_LOG;

  // Bounds kept one bit wider than the counters so a box running past 2047 cannot wrap.
  localparam logic [11:0]      X_LO = 12'(BOX_X);
  localparam logic [11:0]      X_HI = 12'(BOX_X + BOX_W);
  localparam logic [11:0]      Y_LO = 12'(BOX_Y);
  localparam logic [11:0]      Y_HI = 12'(BOX_Y + BOX_H);
  localparam logic [CNT_W-1:0] X0   = CNT_W'(BOX_X);
  localparam logic [CNT_W-1:0] Y0   = CNT_W'(BOX_Y);

  localparam int TW = 2 * CNT_W + 4;
  localparam int PW = 1 + 3 + 1 + RGB_W;

  settings_t            sh;
  logic [BLINK_LOG:0]   frame_cnt;
  logic                 frame_start;

  logic                 in_box;
  logic [8:0]           rel_x;
  logic [7:0]           rel_y;
  logic                 cursor_hit;

  logic                 s1_in_box;
  logic [2:0]           s1_bitsel;
  logic                 s1_cursor;
  logic [RGB_W-1:0]     s1_rgb;

  logic                 d_in_box;
  logic [2:0]           d_bitsel;
  logic                 d_cursor;
  logic [RGB_W-1:0]     d_rgb;
  logic                 pix;
  logic [RGB_W-1:0]     rgb_next;

  assign frame_start = (hcount_in == '0) && (vcount_in == '0);

  // Capture settings and advance the blink counter once per frame.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      sh        <= SETTINGS_DEFAULT;
      frame_cnt <= '0;
    end else if (frame_start) begin
      sh.fg         <= fg_rgb;
      sh.bg         <= bg_rgb;
      sh.mode       <= mode;
      sh.cursor_en  <= cursor_en;
      sh.cursor_col <= cursor_col;
      sh.cursor_row <= cursor_row;
      frame_cnt     <= frame_cnt + 1'b1;
    end
  end

  // Box hit test and glyph-space coordinates; offsets are forced to 0 outside the box.
  always_comb begin
    in_box = ({1'b0, hcount_in} >= X_LO) && ({1'b0, hcount_in} < X_HI) &&
             ({1'b0, vcount_in} >= Y_LO) && ({1'b0, vcount_in} < Y_HI);
    rel_x  = '0;
    rel_y  = '0;
    if (in_box) begin
      rel_x = 9'((hcount_in - X0) >> SCALE_LOG);
      rel_y = 8'((vcount_in - Y0) >> SCALE_LOG);
    end
    cursor_hit = in_box && sh.cursor_en && frame_cnt[BLINK_LOG] &&
                 (rel_y[7:4] == sh.cursor_row) && (rel_x[8:3] == sh.cursor_col);
  end

  // Address stage: present cell and glyph row to the ROMs, register per-pixel attributes.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      char_xy   <= '0;
      char_line <= '0;
      s1_in_box <= 1'b0;
      s1_bitsel <= '0;
      s1_cursor <= 1'b0;
      s1_rgb    <= '0;
    end else begin
      char_xy   <= {rel_y[7:4], rel_x[8:3]};
      char_line <= rel_y[3:0];
      s1_in_box <= in_box;
      s1_bitsel <= rel_x[2:0];
      s1_cursor <= cursor_hit;
      s1_rgb    <= rgb_in;
    end
  end

  // Pixel attributes wait out the ROM latency so they meet char_pixels.
  vga_delay_line #(
    .WIDTH (PW),
    .DEPTH (ROM_LAT)
  ) u_attr_dl (
    .clk   (pclk),
    .rst_n (rst),
    .din   ({s1_in_box, s1_bitsel, s1_cursor, s1_rgb}),
    .dout  ({d_in_box, d_bitsel, d_cursor, d_rgb})
  );

  // Timing signals travel the full pipeline so they stay aligned with rgb_out.
  vga_delay_line #(
    .WIDTH (TW),
    .DEPTH (LAT)
  ) u_timing_dl (
    .clk   (pclk),
    .rst_n (rst),
    .din   ({hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in}),
    .dout  ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out})
  );

  // Pick the glyph bit for this pixel and apply the colour rules.
  always_comb begin
    pix      = char_pixels[3'd7 - d_bitsel];
    rgb_next = compose_pixel(pix, d_in_box, d_cursor, sh.mode, sh.fg, sh.bg, d_rgb);
  end

  // Output register: last pipeline stage.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      rgb_out <= '0;
    end else begin
      rgb_out <= rgb_next;
    end
  end

endmodule

// File: tb/tb_draw_text_box.sv
// tb/tb_draw_text_box.sv - randomized self-checking bench for draw_text_box
module tb_draw_text_box;

  localparam int BOX_X     = 200;
  localparam int BOX_Y     = 400;
  localparam int COLS      = 30;
  localparam int ROWS      = 2;
  localparam int SCALE_LOG = 0;
  localparam int ROM_LAT   = 2;
  localparam int BLINK_LOG = 1;
  localparam int L         = ROM_LAT + 2;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
  } exp_t;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic [11:0] rgb;
  } pix_t;

  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [7:0]  char_pixels;
  logic [11:0] fg_rgb, bg_rgb;
  logic [1:0]  mode;
  logic        cursor_en;
  logic [5:0]  cursor_col;
  logic [3:0]  cursor_row;
  logic [9:0]  char_xy;
  logic [3:0]  char_line;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  int vectors = 0;
  int miscompares = 0;

  exp_t        q[$];
  pix_t        stim[$];
  logic [13:0] last_xy = '0;
  exp_t        e, o;
  bit          have;
  logic [13:0] xe, xo;

  logic [11:0] m_fg, m_bg;
  logic [1:0]  m_mode;
  logic        m_cen;
  logic [5:0]  m_ccol;
  logic [3:0]  m_crow;
  int          m_frame;

  logic [7:0]  rp [ROM_LAT];

  always #5 pclk = ~pclk;

  draw_text_box #(
    .BOX_X(BOX_X), .BOX_Y(BOX_Y), .COLS(COLS), .ROWS(ROWS),
    .SCALE_LOG(SCALE_LOG), .ROM_LAT(ROM_LAT), .BLINK_LOG(BLINK_LOG)
  ) dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .char_pixels(char_pixels),
    .fg_rgb(fg_rgb), .bg_rgb(bg_rgb), .mode(mode),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .char_xy(char_xy), .char_line(char_line),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  // Font contents: glyph row 0 is 1000_0001 for every character.
  function automatic logic [7:0] glyph(input logic [9:0] xy, input logic [3:0] ln);
    int t;
    if (ln == 4'd0) return 8'h81;
    t = int'(xy) * 7 + int'(ln) * 29;
    return t[7:0] ^ 8'hA5 ^ {xy[9:6], ln};
  endfunction

  // External char/font ROM pair with ROM_LAT cycles of latency.
  always @(posedge pclk) begin
    rp[0] <= glyph(char_xy, char_line);
    for (int i = 1; i < ROM_LAT; i++) rp[i] <= rp[i-1];
  end
  assign char_pixels = rp[ROM_LAT-1];

  task automatic model_reset();
    m_fg = 12'hFFF; m_bg = 12'h000; m_mode = 2'b00;
    m_cen = 1'b0; m_ccol = '0; m_crow = '0; m_frame = 0;
  endtask

  // One pixel per clock: sample outputs, apply inputs, predict the result L cycles on.
  task automatic step(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb,
                      output exp_t ee, output exp_t oo, output bit hv,
                      output logic [13:0] xee, output logic [13:0] xoo);
    exp_t n;
    logic [3:0]  sb;
    int          rx, ry, col, row, ln, bt;
    bit          inb, cur, pix;
    logic [11:0] f, b, r;
    logic [7:0]  g;
    @(negedge pclk);
    oo  = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
    hv  = (q.size() == L);
    ee  = '0;
    if (hv) ee = q.pop_front();
    xoo = {char_xy, char_line};
    xee = last_xy;
    sb  = 4'($urandom);
    hcount_in = h; vcount_in = v; rgb_in = rgb;
    {hsync_in, vsync_in, hblnk_in, vblnk_in} = sb;
    n = '0;
    last_xy = '0;
    if (rst) begin
      if (h == 0 && v == 0) begin
        m_fg = fg_rgb; m_bg = bg_rgb; m_mode = mode;
        m_cen = cursor_en; m_ccol = cursor_col; m_crow = cursor_row;
        m_frame++;
      end
      r   = rgb;
      inb = int'(h) >= BOX_X && int'(h) < BOX_X + ((COLS * 8) << SCALE_LOG) &&
            int'(v) >= BOX_Y && int'(v) < BOX_Y + ((ROWS * 16) << SCALE_LOG);
      if (inb) begin
        rx  = (int'(h) - BOX_X) >> SCALE_LOG;
        ry  = (int'(v) - BOX_Y) >> SCALE_LOG;
        col = rx / 8;  bt = rx % 8;
        row = ry / 16; ln = ry % 16;
        last_xy = {4'(row), 6'(col), 4'(ln)};
        g   = glyph({4'(row), 6'(col)}, 4'(ln));
        pix = g[7 - bt];
        cur = m_cen && col == int'(m_ccol) && row == int'(m_crow) &&
              (((m_frame >> BLINK_LOG) & 1) == 1);
        f = cur ? m_bg : m_fg;
        b = cur ? m_fg : m_bg;
        case (m_mode)
          2'b00: r = pix ? f : b;
          2'b01: r = pix ? f : (cur ? b : rgb);
          2'b11: r = pix ? b : f;
          default: r = rgb;
        endcase
      end
      n = {h, v, sb, r};
    end
    q.push_back(n);
  endtask

  task automatic add_px(input int h, input int v);
    stim.push_back({11'(h), 11'(v), 12'($urandom)});
  endtask

  task automatic add_fs();
    for (int i = 0; i < L; i++) add_px(600, 300);
    add_px(0, 0);
  endtask

  task automatic add_rand(input int n);
    for (int i = 0; i < n; i++) add_px(190 + $urandom_range(0, 260), 395 + $urandom_range(0, 42));
  endtask

  task automatic test_reset();
    rst = 1'b0;
    fg_rgb = 12'h123; bg_rgb = 12'h456; mode = 2'b11;
    cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      step(11'(i * 37), 11'(i * 11), 12'($urandom), e, o, have, xe, xo);
      vectors++;
      if ({o, xo} !== '0) begin
        miscompares++;
        $display("FAIL reset_zero cyc%0d got=%h/%h exp=0", i, o, xo);
      end
    end
    @(posedge pclk); #2; rst = 1'b1;
    // Shadows must hold defaults until a frame start despite different inputs.
    for (int h = 196; h < 212; h++) add_px(h, 400);
    add_rand(10);
    for (int i = 0; i < stim.size(); i++) begin
      step(stim[i].h, stim[i].v, stim[i].rgb, e, o, have, xe, xo);
      if (have) begin
        vectors++;
        if (o !== e) begin
          miscompares++;
          $display("FAIL reset_release px%0d got=%h exp=%h", i, o, e);
        end
      end
    end
    stim.delete();
  endtask

  task automatic test_opaque_pattern();
    fg_rgb = 12'hFFF; bg_rgb = 12'h000; mode = 2'b00; cursor_en = 1'b0;
    add_fs();
    add_px(199, 400); add_px(200, 400); add_px(201, 400); add_px(207, 400);
    add_px(439, 400); add_px(440, 400); add_px(300, 399); add_px(300, 432);
    add_rand(30);
    for (int i = 0; i < stim.size(); i++) begin
      step(stim[i].h, stim[i].v, stim[i].rgb, e, o, have, xe, xo);
      vectors++;
      if (xo !== xe) begin
        miscompares++;
        $display("FAIL opaque_addr px%0d got=%h exp=%h", i, xo, xe);
      end
      if (have) begin
        vectors++;
        if (o !== e) begin
          miscompares++;
          $display("FAIL opaque px%0d got=%h exp=%h", i, o, e);
        end
      end
    end
    stim.delete();
  endtask

  task automatic test_modes();
    logic [1:0]  ms [3];
    logic [11:0] fgs [3];
    logic [11:0] bgs [3];
    ms[0] = 2'b01; fgs[0] = 12'hFFF; bgs[0] = 12'h00F;
    ms[1] = 2'b11; fgs[1] = 12'hFFF; bgs[1] = 12'h00F;
    ms[2] = 2'b10; fgs[2] = 12'hABC; bgs[2] = 12'h321;
    for (int m = 0; m < 3; m++) begin
      mode = ms[m]; fg_rgb = fgs[m]; bg_rgb = bgs[m];
      add_fs();
      stim.push_back({11'd201, 11'd400, 12'h0F0});
      stim.push_back({11'd200, 11'd400, 12'h0F0});
      add_rand(40);
      for (int i = 0; i < stim.size(); i++) begin
        step(stim[i].h, stim[i].v, stim[i].rgb, e, o, have, xe, xo);
        if (have) begin
          vectors++;
          if (o !== e) begin
            miscompares++;
            $display("FAIL mode%0d px%0d got=%h exp=%h", ms[m], i, o, e);
          end
        end
      end
      stim.delete();
    end
  endtask

  task automatic test_cursor();
    mode = 2'b00; fg_rgb = 12'hFFF; bg_rgb = 12'h000;
    cursor_en = 1'b1; cursor_row = 4'd0; cursor_col = 6'd3;
    for (int fr = 0; fr < 8; fr++) begin
      add_fs();
      for (int h = 222; h < 234; h++) add_px(h, 400 + $urandom_range(0, 31));
    end
    cursor_col = 6'd40;
    for (int fr = 0; fr < 4; fr++) begin
      add_fs();
      for (int h = 200; h < 440; h += 7) add_px(h, 400 + $urandom_range(0, 31));
    end
    for (int i = 0; i < stim.size(); i++) begin
      if (i == 8 * (L + 13)) cursor_col = 6'd40;
      step(stim[i].h, stim[i].v, stim[i].rgb, e, o, have, xe, xo);
      if (have) begin
        vectors++;
        if (o !== e) begin
          miscompares++;
          $display("FAIL cursor px%0d got=%h exp=%h", i, o, e);
        end
      end
    end
    stim.delete();
    cursor_en = 1'b0;
  endtask

  task automatic test_shadow();
    int chg;
    mode = 2'b00; fg_rgb = 12'hFFF; bg_rgb = 12'h000;
    add_fs();
    add_px(300, 100);
    chg = stim.size();
    add_rand(30);
    add_fs();
    add_rand(30);
    for (int i = 0; i < stim.size(); i++) begin
      if (i == chg) fg_rgb = 12'hF00;
      step(stim[i].h, stim[i].v, stim[i].rgb, e, o, have, xe, xo);
      if (have) begin
        vectors++;
        if (o !== e) begin
          miscompares++;
          $display("FAIL shadow px%0d got=%h exp=%h", i, o, e);
        end
      end
    end
    stim.delete();
  endtask

  task automatic test_reset_midstream();
    add_rand(10);
    for (int i = 0; i < stim.size(); i++) begin
      step(stim[i].h, stim[i].v, stim[i].rgb, e, o, have, xe, xo);
      if (have) begin
        vectors++;
        if (o !== e) begin
          miscompares++;
          $display("FAIL pre_reset px%0d got=%h exp=%h", i, o, e);
        end
      end
    end
    stim.delete();
    rst = 1'b0;
    for (int i = 0; i < q.size(); i++) q[i] = '0;
    last_xy = '0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      step(11'(200 + i), 11'd400, 12'($urandom), e, o, have, xe, xo);
      vectors++;
      if ({o, xo} !== '0) begin
        miscompares++;
        $display("FAIL midreset_zero cyc%0d got=%h/%h exp=0", i, o, xo);
      end
    end
    @(posedge pclk); #2; rst = 1'b1;
    add_rand(20);
    add_fs();
    add_rand(20);
    for (int i = 0; i < stim.size(); i++) begin
      step(stim[i].h, stim[i].v, stim[i].rgb, e, o, have, xe, xo);
      if (have) begin
        vectors++;
        if (o !== e) begin
          miscompares++;
          $display("FAIL post_reset px%0d got=%h exp=%h", i, o, e);
        end
      end
    end
    stim.delete();
  endtask

  task automatic test_back_to_back();
    for (int fr = 0; fr < 10; fr++) begin
      mode = 2'($urandom_range(0, 3));
      fg_rgb = 12'($urandom); bg_rgb = 12'($urandom);
      cursor_en = 1'($urandom); cursor_col = 6'($urandom_range(0, 33));
      cursor_row = 4'($urandom_range(0, 2));
      add_fs();
      add_rand(50);
      for (int i = 0; i < stim.size(); i++) begin
        step(stim[i].h, stim[i].v, stim[i].rgb, e, o, have, xe, xo);
        vectors++;
        if (xo !== xe) begin
          miscompares++;
          $display("FAIL b2b_addr fr%0d px%0d got=%h exp=%h", fr, i, xo, xe);
        end
        if (have) begin
          vectors++;
          if (o !== e) begin
            miscompares++;
            $display("FAIL b2b fr%0d px%0d got=%h exp=%h", fr, i, o, e);
          end
        end
      end
      stim.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < ROM_LAT; i++) rp[i] = '0;
    hcount_in = '0; vcount_in = '0; rgb_in = '0;
    hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
    test_reset();
    test_opaque_pattern();
    test_modes();
    test_cursor();
    test_shadow();
    test_reset_midstream();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
